// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes the operands LSB-first,
// one bit per clock, with the carry held in a flop between bits.

module full_adder (
  input  logic din_a,
  input  logic din_b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = din_a ^ din_b ^ c_in;
  assign c_out = (din_a & din_b) | (c_in & (din_a ^ din_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             sub_q;
  logic             carry;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .din_a (a_sh[0]),
    .din_b (b_sh[0] ^ sub_q),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // Result fills from the MSB end, so after WIDTH shifts bit 0 sits at res[0].
  assign res_nxt = {fa_s, {(WIDTH-1){1'b0}}} | (res >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= din_a;
            b_sh  <= din_b;
            sub_q <= sub;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Outputs load on the way into DONE so they are valid while done is high;
            // carry still holds the carry into the MSB at this point.
            sum   <= res_nxt;
            c_out <= fa_co;
            ovf   <= carry ^ fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl against a plain-arithmetic reference.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] din_a = '0;
  logic [W-1:0] din_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int total = 0;
  int bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .din_a (din_a),
    .din_b (din_b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0] t;
    int sa, sb, sr;
    if (s) t = {1'b0, a} + {1'b0, ~b} + 1;
    else   t = {1'b0, a} + {1'b0, b};
    r  = t[W-1:0];
    co = t[W];
    sa = $signed(a);
    sb = $signed(b);
    sr = s ? sa - sb : sa + sb;
    ov = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
  endfunction

  // Issues one request and follows it to done; inj>0 pulses a competing start at that cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int inj, input string tag);
    logic [W-1:0] er;
    logic eco, eov;
    int n;
    bit seen;
    model(a, b, s, er, eco, eov);
    @(negedge clk);
    start = 1'b1; din_a = a; din_b = b; sub = s;
    n = 0; seen = 0;
    while (!seen && n < W + 6) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0; din_a = W'($urandom); din_b = W'($urandom); sub = 1'($urandom);
      end
      if (inj != 0 && n == inj) begin
        start = 1'b1; din_a = '1; din_b = '1; sub = 1'b0;
      end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (done) seen = 1;
      else if (n <= W) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_lat"}, seen ? n : 0, W + 1);
    if (seen) begin
      chk({tag, "_sum"}, 32'(sum), 32'(er));
      chk({tag, "_cout"}, 32'(c_out), 32'(eco));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic eco, eov;
    bit rs, any_done, bad_done;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    run_op(8'h10, 8'h20, 1'b1, 0, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 0, "sub_80_01");

    run_op(8'h01, 8'h01, 1'b0, 3, "ignored_start");
    repeat (4) begin
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'h02);
      chk("hold_done", 32'(done), 32'd0);
    end

    // Reset four cycles into RUN must discard the operation.
    @(negedge clk);
    start = 1'b1; din_a = 8'h7F; din_b = 8'h01; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    any_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    chk("midrst_nodone", 32'(any_done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(c_out), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, 0, "after_rst");

    // start held high: one accepted operation every W+2 cycles.
    @(negedge clk);
    start = 1'b1; din_a = 8'h11; din_b = 8'h22; sub = 1'b0;
    bad_done = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 30) start = 1'b0;
      if (n == 9 || n == 19 || n == 29) begin
        chk($sformatf("b2b_done_%0d", n), 32'(done), 32'd1);
        chk($sformatf("b2b_sum_%0d", n), 32'(sum), 32'h33);
      end else if (done || (busy && done)) begin
        bad_done = 1;
      end
    end
    chk("b2b_no_extra_done", 32'(bad_done), 32'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, 0, $sformatf("rand%0d", i));
      model(ra, rb, rs, er, eco, eov);
      @(negedge clk);
      chk($sformatf("rand%0d_hold", i), 32'(sum), 32'(er));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
